sha256_compress_unrolled: RTL and testbench

- Parametrised successor to the 2-round unfolded SHA-256 compression core. Performs UNROLL rounds per clock, where UNROLL is 1, 2, 4 or 8.
- Chains hash state across multi-block messages. A `first_block` input reloads the IV per message.
- Sits between the message-schedule unit, which supplies W and K lanes through a valid/ready handshake, and the digest output / padding controller.

---
 rtl/sha256_compress_unrolled_if.sv | 39 +++
 rtl/sha256_compress_unrolled.sv | 126 ++++++++++++
 tb/tb_sha256_compress_unrolled.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_compress_unrolled_if.sv
// Handshake and data bundle between the SHA-256 compression core, its message-schedule feeder and digest consumer.
// SHA256_SHA224_MODE_EN adds the mode224 select that travels with start.
interface sha256_compress_unrolled_if #(
   parameter int UNROLL = 2
);
   logic                   start;
   logic                   first_block;
`ifdef SHA256_SHA224_MODE_EN
   logic                   mode224;
`endif
   logic                   sched_valid;
   logic                   sched_ready;
   logic [UNROLL*32-1:0]   W_in;
   logic [UNROLL*32-1:0]   K_in;
   logic [5:0]             t;
   logic                   busy;
   logic                   digest_valid;
   logic [255:0]           H_out;

`ifdef SHA256_SHA224_MODE_EN
   modport master (
      output start, first_block, mode224, sched_valid, W_in, K_in,
      input  sched_ready, t, busy, digest_valid, H_out
   );
   modport slave (
      input  start, first_block, mode224, sched_valid, W_in, K_in,
      output sched_ready, t, busy, digest_valid, H_out
   );
`else
   modport master (
      output start, first_block, sched_valid, W_in, K_in,
      input  sched_ready, t, busy, digest_valid, H_out
   );
   modport slave (
      input  start, first_block, sched_valid, W_in, K_in,
      output sched_ready, t, busy, digest_valid, H_out
   );
`endif
endinterface

// File: rtl/sha256_compress_unrolled.sv
// SHA-256 block compression, UNROLL rounds per cycle; digest_valid 64/UNROLL+2 cycles after start, +1 per sched_valid stall.
// Round groups are consumed only when sched_valid is high; SHA256_SHA224_MODE_EN enables the SHA-224 IV via mode224.
module sha256_compress_unrolled #(
   parameter int UNROLL = 2,
   parameter int RW     = 6
) (
   input  logic clk,
   input  logic rst_n,
   sha256_compress_unrolled_if.slave bus
);
   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha256_compress_unrolled: UNROLL must be 1, 2, 4 or 8");
   end
   if (RW != 6) begin : g_bad_rw
      $error("sha256_compress_unrolled: RW must be 6");
   end

   typedef logic [0:7][31:0] st_t;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   localparam st_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA256_SHA224_MODE_EN
   localparam st_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                            32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

   // The counter holds the round index itself, so it wraps to zero after the last group.
   localparam logic [RW-1:0] STEP = RW'(UNROLL);
   localparam logic [RW-1:0] LAST = RW'(64 - UNROLL);

   logic [1:0]    state;
   st_t           h_reg;
   st_t           wv;
   logic [RW-1:0] cnt;
   logic          dv;
   st_t           iv_sel;
   st_t           grp_out;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Element 0..7 of the state vector is a..h.
   function automatic st_t do_round(input st_t v, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] t1;
      logic [31:0] t2;
      st_t         n;
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      n[0] = t1 + t2;
      n[1] = v[0];
      n[2] = v[1];
      n[3] = v[2];
      n[4] = v[3] + t1;
      n[5] = v[4];
      n[6] = v[5];
      n[7] = v[6];
      return n;
   endfunction

   always_comb begin
      st_t v;
      v = wv;
      for (int j = 0; j < UNROLL; j++) begin
         v = do_round(v, bus.K_in[32*j +: 32], bus.W_in[32*j +: 32]);
      end
      grp_out = v;
   end

`ifdef SHA256_SHA224_MODE_EN
   assign iv_sel = bus.mode224 ? IV224 : IV256;
`else
   assign iv_sel = IV256;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         h_reg <= IV256;
         wv    <= '0;
         cnt   <= '0;
         dv    <= 1'b0;
      end else begin
         dv <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.first_block) begin
                     h_reg <= iv_sel;
                     wv    <= iv_sel;
                  end else begin
                     wv    <= h_reg;
                  end
                  cnt   <= '0;
                  state <= S_ROUND;
               end
            end
            S_ROUND: begin
               if (bus.sched_valid) begin
                  wv  <= grp_out;
                  cnt <= cnt + STEP;
                  if (cnt == LAST) state <= S_FINAL;
               end
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
               dv    <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.sched_ready  = (state == S_ROUND);
   assign bus.t            = (state == S_ROUND) ? cnt : '0;
   assign bus.busy         = (state != S_IDLE);
   assign bus.digest_valid = dv;
   assign bus.H_out        = h_reg;
endmodule

// File: tb/tb_sha256_compress_unrolled.sv
// Directed bench: one core per UNROLL value (1, 2, 4, 8) fed by a bench-side message schedule and K table.
// The UNROLL=2 core covers single-block, stall, busy/back-to-back, reset and SHA-224; the others the two-block message.
module tb_sha256_compress_unrolled;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [0:63][31:0] KT = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [255:0] IV256  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [0:15][31:0] MSG_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [0:15][31:0] MSG_T1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [0:15][31:0] MSG_T2  = {{15{32'h0}}, 32'h000001c0};

   logic [0:63][31:0] wsch = '0;

   logic start_m = 1'b0, fb_m = 1'b0;
   logic start2 = 1'b0, fb2 = 1'b0, sv2 = 1'b1;
   logic m224 = 1'b0;

   sha256_compress_unrolled_if #(.UNROLL(1)) b1 ();
   sha256_compress_unrolled_if #(.UNROLL(2)) b2 ();
   sha256_compress_unrolled_if #(.UNROLL(4)) b4 ();
   sha256_compress_unrolled_if #(.UNROLL(8)) b8 ();

   sha256_compress_unrolled #(.UNROLL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   sha256_compress_unrolled #(.UNROLL(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   sha256_compress_unrolled #(.UNROLL(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   sha256_compress_unrolled #(.UNROLL(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   function automatic logic [255:0] lanes(input logic [0:63][31:0] tab, input logic [5:0] t, input int u);
      logic [255:0] r;
      r = '0;
      for (int j = 0; j < u; j++) r[32*j +: 32] = tab[int'(t) + j];
      return r;
   endfunction

   assign b1.start = start_m;  assign b1.first_block = fb_m;  assign b1.sched_valid = 1'b1;
   assign b4.start = start_m;  assign b4.first_block = fb_m;  assign b4.sched_valid = 1'b1;
   assign b8.start = start_m;  assign b8.first_block = fb_m;  assign b8.sched_valid = 1'b1;
   assign b2.start = start2;   assign b2.first_block = fb2;   assign b2.sched_valid = sv2;
`ifdef SHA256_SHA224_MODE_EN
   assign b1.mode224 = 1'b0;
   assign b2.mode224 = m224;
   assign b4.mode224 = 1'b0;
   assign b8.mode224 = 1'b0;
`endif
   assign b1.W_in = 32'(lanes(wsch, b1.t, 1));   assign b1.K_in = 32'(lanes(KT, b1.t, 1));
   assign b2.W_in = 64'(lanes(wsch, b2.t, 2));   assign b2.K_in = 64'(lanes(KT, b2.t, 2));
   assign b4.W_in = 128'(lanes(wsch, b4.t, 4));  assign b4.K_in = 128'(lanes(KT, b4.t, 4));
   assign b8.W_in = lanes(wsch, b8.t, 8);        assign b8.K_in = lanes(KT, b8.t, 8);

   // Digest pulse monitor, index 0..3 = UNROLL 1, 2, 4, 8.
   int           dv_cnt [4] = '{default: 0};
   int           dv_cyc [4] = '{default: 0};
   logic [255:0] dv_h   [4];
   always @(negedge clk) begin
      if (b1.digest_valid) begin dv_cnt[0]++; dv_cyc[0] = cyc; dv_h[0] = b1.H_out; end
      if (b2.digest_valid) begin dv_cnt[1]++; dv_cyc[1] = cyc; dv_h[1] = b2.H_out; end
      if (b4.digest_valid) begin dv_cnt[2]++; dv_cyc[2] = cyc; dv_h[2] = b4.H_out; end
      if (b8.digest_valid) begin dv_cnt[3]++; dv_cyc[3] = cyc; dv_h[3] = b8.H_out; end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic load_block(input logic [0:15][31:0] m);
      logic [0:63][31:0] w;
      for (int i = 0; i < 16; i++) w[i] = m[i];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      wsch = w;
   endtask

   task automatic wait_dv(input int idx, input int want, input string tag);
      int n;
      n = 0;
      while (dv_cnt[idx] < want && n < 300) begin
         tick();
         n++;
      end
      chk(tag, 256'(dv_cnt[idx] >= want), 256'(1));
   endtask

   int  s, n, nst, k, r;
   logic [5:0] held;
   bit  stall_t [64];

   initial begin
      tick(); tick();
      chk("rst_h_out",  b2.H_out, IV256);
      chk("rst_h_out8", b8.H_out, IV256);
      chk("rst_busy",   256'(b2.busy), 256'(0));
      chk("rst_ready",  256'(b2.sched_ready), 256'(0));
      chk("rst_dv",     256'(b2.digest_valid), 256'(0));
      chk("rst_t",      256'(b2.t), 256'(0));
      rst_n = 1'b1;
      tick();

      // Single block "abc", no stalls
      load_block(MSG_ABC);
      start2 = 1'b1; fb2 = 1'b1; s = cyc;
      tick();
      start2 = 1'b0;
      wait_dv(1, 1, "abc_done");
      chk("abc_digest", dv_h[1], D_ABC);
      chk("abc_latency", 256'(dv_cyc[1] - s), 256'(34));
      chk("abc_pulses", 256'(dv_cnt[1]), 256'(1));

      // Five stalls: four random groups plus the last group at t=62
      for (int i = 0; i < 64; i++) stall_t[i] = 1'b0;
      stall_t[62] = 1'b1;
      k = 0;
      while (k < 4) begin
         r = 2 * int'($urandom_range(30, 0));
         if (!stall_t[r]) begin stall_t[r] = 1'b1; k++; end
      end
      start2 = 1'b1; fb2 = 1'b1; s = cyc;
      tick();
      start2 = 1'b0;
      n = 0; nst = 0;
      while (dv_cnt[1] < 2 && n < 300) begin
         if (b2.sched_ready && stall_t[b2.t]) begin
            stall_t[b2.t] = 1'b0;
            held = b2.t;
            sv2 = 1'b0;
            nst++;
            tick();
            chk("stall_t_hold", 256'(b2.t), 256'(held));
            sv2 = 1'b1;
         end else begin
            tick();
         end
         n++;
      end
      sv2 = 1'b1;
      chk("stall_count", 256'(nst), 256'(5));
      chk("stall_digest", dv_h[1], D_ABC);
      chk("stall_latency", 256'(dv_cyc[1] - s), 256'(39));

      // Starts while busy are ignored; a start coincident with digest_valid is taken
      start2 = 1'b1; fb2 = 1'b1; s = cyc;
      tick();
      start2 = 1'b0;
      n = 0;
      while (!b2.digest_valid && n < 100) begin
         start2 = (cyc == s + 3) || (cyc == s + 20);
         tick();
         n++;
      end
      chk("busy_latency", 256'(cyc - s), 256'(34));
      chk("busy_digest", b2.H_out, D_ABC);
      start2 = 1'b1; fb2 = 1'b1; s = cyc;
      tick();
      start2 = 1'b0;
      chk("b2b_busy", 256'(b2.busy), 256'(1));
      wait_dv(1, 4, "b2b_done");
      chk("b2b_latency", 256'(dv_cyc[1] - s), 256'(34));
      chk("b2b_digest", dv_h[1], D_ABC);

      // Reset in the middle of a block discards it
      start2 = 1'b1; fb2 = 1'b1;
      tick();
      start2 = 1'b0;
      n = 0;
      while (!(b2.sched_ready && b2.t == 6'd40) && n < 100) begin
         tick();
         n++;
      end
      chk("rst_mid_reach_t40", 256'(b2.t), 256'(40));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_mid_h_out", b2.H_out, IV256);
      chk("rst_mid_busy", 256'(b2.busy), 256'(0));
      chk("rst_mid_ready", 256'(b2.sched_ready), 256'(0));
      for (int i = 0; i < 40; i++) tick();
      chk("rst_mid_no_pulse", 256'(dv_cnt[1]), 256'(4));
      start2 = 1'b1; fb2 = 1'b0; s = cyc;
      tick();
      start2 = 1'b0;
      wait_dv(1, 5, "rst_after_done");
      chk("rst_after_digest", dv_h[1], D_ABC);
      chk("rst_after_latency", 256'(dv_cyc[1] - s), 256'(34));

      // Two-block message on UNROLL 1, 4, 8 with chaining
      load_block(MSG_T1);
      start_m = 1'b1; fb_m = 1'b1; s = cyc;
      tick();
      start_m = 1'b0;
      wait_dv(0, 1, "two_b1_done_u1");
      chk("two_b1_lat_u1", 256'(dv_cyc[0] - s), 256'(66));
      chk("two_b1_lat_u4", 256'(dv_cyc[2] - s), 256'(18));
      chk("two_b1_lat_u8", 256'(dv_cyc[3] - s), 256'(10));
      load_block(MSG_T2);
      start_m = 1'b1; fb_m = 1'b0; s = cyc;
      tick();
      start_m = 1'b0;
      wait_dv(0, 2, "two_b2_done_u1");
      chk("two_lat_u1", 256'(dv_cyc[0] - s), 256'(66));
      chk("two_lat_u4", 256'(dv_cyc[2] - s), 256'(18));
      chk("two_lat_u8", 256'(dv_cyc[3] - s), 256'(10));
      chk("two_digest_u1", dv_h[0], D_TWO);
      chk("two_digest_u4", dv_h[2], D_TWO);
      chk("two_digest_u8", dv_h[3], D_TWO);
      chk("two_hold_u8", b8.H_out, D_TWO);

`ifdef SHA256_SHA224_MODE_EN
      load_block(MSG_ABC);
      start2 = 1'b1; fb2 = 1'b1; m224 = 1'b1;
      tick();
      start2 = 1'b0; m224 = 1'b0;
      wait_dv(1, 6, "sha224_done");
      chk("sha224_digest", 256'(dv_h[1][255:32]),
          256'(224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
